position_avg: RTL
=================

POSITION_AVG -- requirements
Module: position_avg

Interface
REQ-001 The module SHALL have parameter AVG_LOG2_MAX, default 8: largest supported log2 of the averaging window.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 enable  input  1  high = averaging active; low = block idle.
REQ-005 clear  input  1  synchronous discard of the partial window.
REQ-006 avg_log2  input  4  window size N = 2^avg_log2 samples.
REQ-007 in_valid  input  1  one-cycle strobe from the position stage rdy; X_IN/Y_IN/S_IN are valid in the same cycle.
REQ-008 X_IN, Y_IN, S_IN  input  32 each  signed two's-complement fixed-point position and sum results.
REQ-009 X_AVG, Y_AVG, S_AVG  output  32 each  window averages; registered.
REQ-010 avg_rdy  output  1  one-cycle pulse when new averages are presented.
REQ-011 sample_cnt  output  9  samples accumulated in the current window.
REQ-012 window_cnt  output  16  completed windows since reset; wraps.

Function
REQ-013 The FSM SHALL have two states: IDLE and ACCUM.
- IDLE -> ACCUM when enable=1.
- ACCUM -> IDLE when enable=0.
REQ-014 Effective window exponent n SHALL be min(avg_log2, AVG_LOG2_MAX).
- n SHALL be latched on IDLE->ACCUM, on every window completion and on clear.
- avg_log2 changes mid-window SHALL have no effect until the next latch.
REQ-015 The three accumulators SHALL be signed, 32+AVG_LOG2_MAX bits wide, with sign-extended inputs; they SHALL never overflow.
REQ-016 In ACCUM with in_valid=1 and clear=0:
- if sample_cnt+1 < 2^n: add inputs to the accumulators and increment sample_cnt.
- otherwise: complete the window.
REQ-017 On window completion, the following SHALL all occur on the same clock edge:
- X_AVG/Y_AVG/S_AVG <= (acc + input) arithmetically shifted right by n (rounds toward minus infinity), truncated to 32 bits.
- avg_rdy pulses high for exactly the following cycle.
- accumulators and sample_cnt <= 0.
- window_cnt increments.
REQ-018 Latency SHALL be one clock from the final in_valid to avg_rdy; there is no dead cycle, so in_valid in the cycle after completion SHALL be accepted as sample 1 of the next window.
REQ-019 With n=0, every sample SHALL be passed through to the outputs with one-cycle latency, and avg_rdy SHALL pulse for each sample.
REQ-020 clear=1 SHALL zero the accumulators and sample_cnt; X_AVG/Y_AVG/S_AVG, window_cnt and state SHALL hold.
- clear has priority over a simultaneous in_valid; that sample SHALL be dropped with no avg_rdy.
REQ-021 In IDLE, or when enable=0 in the same cycle as in_valid, the sample SHALL be dropped.
- On ACCUM->IDLE the partial window SHALL be discarded (accumulators and sample_cnt <= 0).
- Outputs SHALL hold their last values.
REQ-022 avg_rdy SHALL never be high for two consecutive cycles unless in_valid was high in the two preceding consecutive cycles with n=0.
REQ-023 window_cnt SHALL wrap from 0xFFFF to 0x0000 without side effects.

Reset
REQ-024 While rst=0 (asynchronously), all of the following SHALL be 0 and the state SHALL be IDLE:
- X_AVG, Y_AVG, S_AVG, avg_rdy, sample_cnt, window_cnt, accumulators, latched n.
REQ-025 Asserting rst mid-window SHALL discard the partial window.
- After release, the first window SHALL start only once enable=1 is sampled.

Verification
REQ-026 enable=1, avg_log2=2, X_IN = 10, 20, 30, 41 on four strobes -> X_AVG=25, avg_rdy one cycle after the 4th strobe, window_cnt=1.
REQ-027 avg_log2=1, X_IN = -3, -4 -> X_AVG = -4 (floor of -3.5); Y_IN = 0x7FFFFFFF twice -> Y_AVG = 0x7FFFFFFF (no overflow).
REQ-028 avg_log2=3 with 5 samples accumulated, then clear coincident with the 6th strobe -> sample_cnt=0, no avg_rdy, previous averages held; the next 8 samples produce a correct average.
REQ-029 avg_log2=0 with strobes on consecutive cycles -> outputs follow the inputs one cycle later, and avg_rdy stays high throughout.
REQ-030 avg_log2=15 with AVG_LOG2_MAX=8 -> a window completes after exactly 256 strobes.
REQ-031 Assert rst low after 2 samples of a 4-sample window, then release it -> all outputs 0; a fresh 4-sample window is required before avg_rdy.

Source files
------------

// File: rtl/position_avg.sv
// Windowed averaging of the position stage results (X, Y, S) over 2^n samples.
// Each completed window presents floor(sum / 2^n) on the outputs with a one-cycle ready pulse.
module position_avg #(
  parameter int unsigned AVG_LOG2_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic [3:0]         avg_log2,
  input  logic               in_valid,
  input  logic signed [31:0] X_IN,
  input  logic signed [31:0] Y_IN,
  input  logic signed [31:0] S_IN,
  output logic signed [31:0] X_AVG,
  output logic signed [31:0] Y_AVG,
  output logic signed [31:0] S_AVG,
  output logic               avg_rdy,
  output logic [8:0]         sample_cnt,
  output logic [15:0]        window_cnt
);

  localparam int unsigned AccW = 32 + AVG_LOG2_MAX;
  localparam logic [3:0]  NMax = 4'(AVG_LOG2_MAX);

  typedef enum logic {StIdle, StAccum} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             n_q, n_d;
  logic signed [AccW-1:0] acc_x_q, acc_x_d;
  logic signed [AccW-1:0] acc_y_q, acc_y_d;
  logic signed [AccW-1:0] acc_s_q, acc_s_d;
  logic [8:0]             cnt_q, cnt_d;
  logic signed [31:0]     x_avg_q, x_avg_d;
  logic signed [31:0]     y_avg_q, y_avg_d;
  logic signed [31:0]     s_avg_q, s_avg_d;
  logic                   rdy_q, rdy_d;
  logic [15:0]            wcnt_q, wcnt_d;

  logic [3:0]             n_eff;
  logic signed [AccW-1:0] sum_x, sum_y, sum_s;
  logic [16:0]            cnt_inc;
  logic [16:0]            win_size;
  logic                   window_done;

  assign n_eff = (avg_log2 > NMax) ? NMax : avg_log2;

  // Sums include the current sample so the completing strobe lands in the average directly.
  assign sum_x = acc_x_q + AccW'(X_IN);
  assign sum_y = acc_y_q + AccW'(Y_IN);
  assign sum_s = acc_s_q + AccW'(S_IN);

  assign cnt_inc     = 17'(cnt_q) + 17'd1;
  assign win_size    = 17'd1 << n_q;
  assign window_done = (cnt_inc >= win_size);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    acc_s_d = acc_s_q;
    cnt_d   = cnt_q;
    x_avg_d = x_avg_q;
    y_avg_d = y_avg_q;
    s_avg_d = s_avg_q;
    rdy_d   = 1'b0;
    wcnt_d  = wcnt_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StAccum;
          n_d     = n_eff;
        end
      end
      StAccum: begin
        if (!enable) begin
          // Leaving ACCUM throws away the partial window.
          state_d = StIdle;
          acc_x_d = '0;
          acc_y_d = '0;
          acc_s_d = '0;
          cnt_d   = '0;
        end else if (clear) begin
          acc_x_d = '0;
          acc_y_d = '0;
          acc_s_d = '0;
          cnt_d   = '0;
          n_d     = n_eff;
        end else if (in_valid) begin
          if (!window_done) begin
            acc_x_d = sum_x;
            acc_y_d = sum_y;
            acc_s_d = sum_s;
            cnt_d   = cnt_q + 9'd1;
          end else begin
            // Arithmetic shift gives floor division, matching the sign convention downstream.
            x_avg_d = 32'(sum_x >>> n_q);
            y_avg_d = 32'(sum_y >>> n_q);
            s_avg_d = 32'(sum_s >>> n_q);
            rdy_d   = 1'b1;
            acc_x_d = '0;
            acc_y_d = '0;
            acc_s_d = '0;
            cnt_d   = '0;
            wcnt_d  = wcnt_q + 16'd1;
            n_d     = n_eff;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      acc_s_q <= '0;
      cnt_q   <= '0;
      x_avg_q <= '0;
      y_avg_q <= '0;
      s_avg_q <= '0;
      rdy_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      acc_s_q <= acc_s_d;
      cnt_q   <= cnt_d;
      x_avg_q <= x_avg_d;
      y_avg_q <= y_avg_d;
      s_avg_q <= s_avg_d;
      rdy_q   <= rdy_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign X_AVG      = x_avg_q;
  assign Y_AVG      = y_avg_q;
  assign S_AVG      = s_avg_q;
  assign avg_rdy    = rdy_q;
  assign sample_cnt = cnt_q;
  assign window_cnt = wcnt_q;

endmodule
